alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU operand/op interface: accepts operation requests, reads operands from an

---
 rtl/alu_issue_ctrl_pkg.sv | 38 +++
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/alu_issue_ctrl_regfile.sv | 47 ++++
 rtl/alu_issue_ctrl.sv | 119 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared widths, ALU op codes and E-stage record for the ALU issue controller.
// Widths mirror the legacy DATA_BUS / OP_BUS / REG_BUS definitions.
package alu_issue_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int REG_N  = 8;
  localparam int RA_W   = $clog2(REG_N);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [OP_W-1:0]   op_t;
  typedef logic [RA_W-1:0]   ra_t;

  localparam op_t OP_ADD  = 4'd0;
  localparam op_t OP_SUB  = 4'd1;
  localparam op_t OP_AND  = 4'd2;
  localparam op_t OP_OR   = 4'd3;
  localparam op_t OP_XOR  = 4'd4;
  localparam op_t OP_SLL  = 4'd5;
  localparam op_t OP_SRL  = 4'd6;
  localparam op_t OP_SRA  = 4'd7;
  localparam op_t OP_RETA = 4'd8;
  localparam op_t OP_RETB = 4'd9;

  // Execute-stage occupancy: what is currently being presented to the ALU.
  typedef struct packed {
    logic valid;
    op_t  op;
    ra_t  rd;
    logic wen;
  } e_stage_t;

  // True when the E-stage op will write a real (non-R0) register.
  function automatic logic e_writes(e_stage_t e);
    return e.valid && e.wen && (e.rd != '0);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request / ALU / response / debug bundle of the ALU issue controller.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; no rsp backpressure.
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;

  logic  req_valid;
  logic  req_ready;
  op_t   req_op;
  ra_t   req_rs;
  ra_t   req_rt;
  ra_t   req_rd;
  logic  req_use_imm;
  data_t req_imm;
  logic  req_wen;
  logic  flush;

  data_t alu_a;
  data_t alu_b;
  op_t   alu_op;
  data_t alu_y;
  logic  alu_zero;

  logic  rsp_valid;
  data_t rsp_data;
  logic  rsp_zero;
  ra_t   rsp_rd;

  ra_t   dbg_addr;
  data_t dbg_data;

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_use_imm, req_imm, req_wen, flush,
    input  alu_y, alu_zero, dbg_addr,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_zero, rsp_rd, dbg_data
  );

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_use_imm, req_imm, req_wen, flush,
    output alu_y, alu_zero, dbg_addr,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_zero, rsp_rd, dbg_data
  );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// REG_N x DATA_W register file: three combinational read ports, one synchronous write port,
// write-first bypass, R0 hardwired to zero, asynchronous reset to zero.
module alu_issue_ctrl_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  ra_t   rs_addr_i,
  input  ra_t   rt_addr_i,
  input  ra_t   dbg_addr_i,
  input  logic  we_i,
  input  ra_t   wa_i,
  input  data_t wd_i,
  output data_t rs_data_o,
  output data_t rt_data_o,
  output data_t dbg_data_o
);

  data_t regs_q [REG_N];
  logic  wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // A read that coincides with a write to the same register sees the new value.
  function automatic data_t read_port(ra_t addr, logic wen, ra_t wa, data_t wd, data_t cur);
    data_t v;
    if (addr == '0)              v = '0;
    else if (wen && (wa == addr)) v = wd;
    else                         v = cur;
    return v;
  endfunction

  always_comb begin
    rs_data_o  = read_port(rs_addr_i,  wr_en, wa_i, wd_i, regs_q[rs_addr_i]);
    rt_data_o  = read_port(rt_addr_i,  wr_en, wa_i, wd_i, regs_q[rt_addr_i]);
    dbg_data_o = read_port(dbg_addr_i, wr_en, wa_i, wd_i, regs_q[dbg_addr_i]);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: E stage drives the external ALU, W stage writes back and reports.
// Build option ALU_FORWARD_EN: forward the E-stage result on a RAW hazard instead of stalling.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus
);

  e_stage_t e_q, e_d;
  data_t    alu_a_q, alu_a_d;
  data_t    alu_b_q, alu_b_d;
  logic     rsp_valid_q, rsp_valid_d;
  data_t    rsp_data_q, rsp_data_d;
  logic     rsp_zero_q, rsp_zero_d;
  ra_t      rsp_rd_q, rsp_rd_d;

  data_t rs_data, rt_data;
  data_t opnd_a, opnd_b;
  logic  haz_a, haz_b;
  logic  stall;
  logic  accept;
  logic  retire;
  logic  wb_en;

  // An op in E that is being flushed never reaches write-back.
  assign retire = e_q.valid && !bus.flush;
  assign wb_en  = retire && e_q.wen && (e_q.rd != '0);

  alu_issue_ctrl_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rs_addr_i  (bus.req_rs),
    .rt_addr_i  (bus.req_rt),
    .dbg_addr_i (bus.dbg_addr),
    .we_i       (wb_en),
    .wa_i       (e_q.rd),
    .wd_i       (bus.alu_y),
    .rs_data_o  (rs_data),
    .rt_data_o  (rt_data),
    .dbg_data_o (bus.dbg_data)
  );

  // Distance-1 RAW: the incoming request reads a register the E-stage op is about to write.
  assign haz_a = e_writes(e_q) && !bus.req_use_imm && (bus.req_rs == e_q.rd);
  assign haz_b = e_writes(e_q) && (bus.req_rt == e_q.rd);

`ifdef ALU_FORWARD_EN
  assign stall  = 1'b0;
  assign opnd_a = bus.req_use_imm ? bus.req_imm : (haz_a ? bus.alu_y : rs_data);
  assign opnd_b = haz_b ? bus.alu_y : rt_data;
`else
  // One bubble lets the producer retire; the regfile then returns the written value.
  assign stall  = haz_a || haz_b;
  assign opnd_a = bus.req_use_imm ? bus.req_imm : rs_data;
  assign opnd_b = rt_data;
`endif

  assign bus.req_ready = !bus.flush && !stall;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q         <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_rd_q    <= '0;
    end else begin
      e_q         <= e_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // E stage: ALU inputs hold their last value while the stage is empty.
  always_comb begin
    e_d       = e_q;
    e_d.valid = accept;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    if (accept) begin
      e_d.op  = bus.req_op;
      e_d.rd  = bus.req_rd;
      e_d.wen = bus.req_wen;
      alu_a_d = opnd_a;
      alu_b_d = opnd_b;
    end
  end

  // W stage: sample the ALU result and pulse the response for one cycle.
  always_comb begin
    rsp_valid_d = retire;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_rd_d    = rsp_rd_q;
    if (retire) begin
      rsp_data_d = bus.alu_y;
      rsp_zero_d = bus.alu_zero;
      rsp_rd_d   = e_q.rd;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = e_q.op;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: behavioural ALU, response scoreboard, hand-computed vectors.
// Shift ops move b by a[3:0], where a shift field of 0 means 8 (legacy ALU convention).
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

`ifdef ALU_FORWARD_EN
  localparam int RAW_STALL = 0;
`else
  localparam int RAW_STALL = 1;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  // {zero, rd, data}
  logic [DATA_W+RA_W:0] exp_q[$];
  logic [DATA_W+RA_W:0] sb_e;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural combinational ALU
  logic [3:0] sh;
  data_t      y;
  always_comb begin
    sh = (bus.alu_a[3:0] == 4'd0) ? 4'd8 : bus.alu_a[3:0];
    y  = '0;
    case (bus.alu_op)
      OP_ADD:  y = bus.alu_a + bus.alu_b;
      OP_SUB:  y = bus.alu_a - bus.alu_b;
      OP_AND:  y = bus.alu_a & bus.alu_b;
      OP_OR:   y = bus.alu_a | bus.alu_b;
      OP_XOR:  y = bus.alu_a ^ bus.alu_b;
      OP_SLL:  y = bus.alu_b << sh;
      OP_SRL:  y = bus.alu_b >> sh;
      OP_SRA:  y = $signed(bus.alu_b) >>> sh;
      OP_RETA: y = bus.alu_a;
      OP_RETB: y = bus.alu_b;
      default: y = '0;
    endcase
    bus.alu_y    = y;
    bus.alu_zero = (y == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every response pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, sb_e[DATA_W-1:0]});
        check("rsp_rd",   {29'd0, bus.rsp_rd},   {29'd0, sb_e[DATA_W+RA_W-1:DATA_W]});
        check("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, sb_e[DATA_W+RA_W]});
      end
    end
  end

  // driver tasks
  task automatic send(input op_t op, input ra_t rs, input ra_t rt, input ra_t rd,
                      input logic use_imm, input data_t imm, input logic wen,
                      input logic exp_rsp, input data_t exp_data, input int exp_stall);
    int stalls;
    @(negedge clk);
    bus.req_op      = op;
    bus.req_rs      = rs;
    bus.req_rt      = rt;
    bus.req_rd      = rd;
    bus.req_use_imm = use_imm;
    bus.req_imm     = imm;
    bus.req_wen     = wen;
    bus.req_valid   = 1'b1;
    stalls = 0;
    #1;
    while (!bus.req_ready && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!bus.req_ready) begin
      check("req_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
    end else begin
      check("stall_cycles", stalls, exp_stall);
      if (exp_rsp) exp_q.push_back({(exp_data == '0), rd, exp_data});
      @(posedge clk);
    end
  endtask

  task automatic drain(input int n);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_chk(input string tag, input ra_t addr, input data_t exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, {16'd0, bus.dbg_data}, {16'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs = '0; bus.req_rt = '0; bus.req_rd = '0;
    bus.req_use_imm = 1'b0; bus.req_imm = '0; bus.req_wen = 1'b0; bus.flush = 1'b0;
    bus.dbg_addr = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_alu_a",     {16'd0, bus.alu_a},    32'd0);
    check("rst_alu_b",     {16'd0, bus.alu_b},    32'd0);
    check("rst_alu_op",    {28'd0, bus.alu_op},   32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data",  {16'd0, bus.rsp_data}, 32'd0);
    check("rst_rsp_zero",  {31'd0, bus.rsp_zero}, 32'd0);
    check("rst_rsp_rd",    {29'd0, bus.rsp_rd},   32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);

    // 1: reset in the middle of an op
    send(OP_RETA, 3'd0, 3'd0, 3'd1, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 0);
    drain(2);
    reg_chk("t1_r1_loaded", 3'd1, 16'h1234);
    send(OP_RETA, 3'd0, 3'd0, 3'd2, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("t1_inflight_a", {16'd0, bus.alu_a}, 32'h5555);
    rst = 1'b1;
    #1;
    check("t1_rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
    @(negedge clk);
    check("t1_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    reg_chk("t1_rst_r1", 3'd1, 16'h0000);
    reg_chk("t1_rst_r2", 3'd2, 16'h0000);
    rst = 1'b0;
    #1;
    check("t1_ready_after", {31'd0, bus.req_ready}, 32'd1);

    // 2: immediate load
    send(OP_RETA, 3'd0, 3'd0, 3'd1, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("t2_alu_a",  {16'd0, bus.alu_a},  32'h1234);
    check("t2_alu_op", {28'd0, bus.alu_op}, {28'd0, OP_RETA});
    @(negedge clk);
    check("t2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("t2_rsp_data",  {16'd0, bus.rsp_data}, 32'h1234);
    check("t2_rsp_rd",    {29'd0, bus.rsp_rd},   32'd1);
    reg_chk("t2_r1", 3'd1, 16'h1234);
    @(negedge clk);
    check("t2_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // 3: back-to-back RAW
    send(OP_RETA, 3'd0, 3'd0, 3'd1, 1'b1, 16'd5, 1'b1, 1'b1, 16'd5, 0);
    drain(1);
    send(OP_RETA, 3'd0, 3'd0, 3'd2, 1'b1, 16'd3, 1'b1, 1'b1, 16'd3, 0);
    drain(1);
    send(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 16'd0, 1'b1, 1'b1, 16'd8, 0);
    send(OP_SUB, 3'd3, 3'd2, 3'd4, 1'b0, 16'd0, 1'b1, 1'b1, 16'd5, RAW_STALL);
    drain(2);
    reg_chk("t3_r3", 3'd3, 16'd8);
    reg_chk("t3_r4", 3'd4, 16'd5);

    // 4: R0 writes dropped, R0 never forwarded
    send(OP_RETA, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 0);
    send(OP_ADD, 3'd0, 3'd1, 3'd7, 1'b0, 16'd0, 1'b1, 1'b1, 16'd5, 0);
    drain(2);
    reg_chk("t4_r0", 3'd0, 16'h0000);
    reg_chk("t4_r7", 3'd7, 16'd5);

    // 5: flush kills the E-stage op
    send(OP_ADD, 3'd1, 3'd2, 3'd5, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 0);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.req_rd = 3'd6;
    #1;
    check("t5_ready_flush", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("t5_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    reg_chk("t5_r5", 3'd5, 16'h0000);
    reg_chk("t5_r6", 3'd6, 16'h0000);

    // 6: shifts with immediate amount, then a zero result
    send(OP_RETA, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 0);
    drain(1);
    send(OP_SLL, 3'd0, 3'd2, 3'd6, 1'b1, 16'd0, 1'b1, 1'b1, 16'h0100, 0);
    drain(2);
    reg_chk("t6_sll8", 3'd6, 16'h0100);
    send(OP_SLL, 3'd0, 3'd2, 3'd6, 1'b1, 16'd3, 1'b1, 1'b1, 16'h0008, 0);
    drain(2);
    reg_chk("t6_sll3", 3'd6, 16'h0008);
    send(OP_SUB, 3'd4, 3'd4, 3'd7, 1'b0, 16'd0, 1'b1, 1'b1, 16'h0000, 0);
    drain(2);
    reg_chk("t6_r7_zero", 3'd7, 16'h0000);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
